// File: rtl/ws2812_pkg.sv
// ws2812_pkg: shared colour width, default WS2812 timing at 50 MHz and scheduler FSM states.
package ws2812_pkg;
    localparam int COLOR_W        = 24;
    localparam int BIT_CYCLES     = 63;
    localparam int T1H_CYCLES     = 40;
    localparam int T0H_CYCLES     = 20;
    localparam int RESET_CYCLES   = 10000;
    localparam int REFRESH_CYCLES = 2_500_000;
    typedef enum logic [1:0] {IDLE, START, SEND, LATCH} state_t;
endpackage

// File: rtl/ws2812_chain_scheduler_bit_encoder.sv
// ws2812_bit_encoder: turns one handshaken bit into one WS2812 bit period; low when idle.
module ws2812_bit_encoder #(
    parameter int BIT_CYCLES = ws2812_pkg::BIT_CYCLES,
    parameter int T1H_CYCLES = ws2812_pkg::T1H_CYCLES,
    parameter int T0H_CYCLES = ws2812_pkg::T0H_CYCLES
) (
    input  logic clk,
    input  logic rst,
    input  logic bit_valid,
    input  logic bit_val,
    output logic bit_ready,
    output logic data_out
);
    localparam int CW = BIT_CYCLES > 1 ? $clog2(BIT_CYCLES) : 1;
    logic          active;
    logic          val;
    logic [CW-1:0] cnt;
    // Ready in the final cycle of a period lets the next bit follow with no gap.
    assign bit_ready = !active || cnt == CW'(BIT_CYCLES - 1);
    assign data_out  = active && (int'(cnt) < (val ? T1H_CYCLES : T0H_CYCLES));
    always_ff @(posedge clk) begin
        if (rst) begin
            active <= 1'b0;
            val    <= 1'b0;
            cnt    <= '0;
        end else if (bit_ready) begin
            active <= bit_valid;
            val    <= bit_val;
            cnt    <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end
endmodule

// File: rtl/ws2812_chain_scheduler.sv
// ws2812_chain_scheduler: double-buffered pixel store streamed as gapless WS2812 frames plus latch gap.
// Optional periodic refresh is enabled by defining WS2812_AUTO_REFRESH_EN.
module ws2812_chain_scheduler #(
    parameter int NUM_LEDS       = 8,
    parameter int BIT_CYCLES     = ws2812_pkg::BIT_CYCLES,
    parameter int T1H_CYCLES     = ws2812_pkg::T1H_CYCLES,
    parameter int T0H_CYCLES     = ws2812_pkg::T0H_CYCLES,
    parameter int RESET_CYCLES   = ws2812_pkg::RESET_CYCLES,
`ifdef WS2812_AUTO_REFRESH_EN
    parameter int REFRESH_CYCLES = ws2812_pkg::REFRESH_CYCLES,
`endif
    localparam int AW = NUM_LEDS > 1 ? $clog2(NUM_LEDS) : 1
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           wr_en,
    input  logic [AW-1:0]                  wr_addr,
    input  logic [ws2812_pkg::COLOR_W-1:0] wr_data,
    input  logic                           frame_req,
    output logic                           busy,
    output logic                           frame_done,
    output logic                           led_data_out
);
    import ws2812_pkg::*;
    localparam int LW = RESET_CYCLES > 1 ? $clog2(RESET_CYCLES) : 1;
    state_t               state, state_n;
    logic [COLOR_W-1:0]   shadow [NUM_LEDS];
    logic [COLOR_W-1:0]   active [NUM_LEDS];
    logic [AW-1:0]        pix;
    logic [4:0]           bit_idx;
    logic [LW-1:0]        lat_cnt;
    logic                 last, pending, req, wr_ok, latch_end;
    logic                 bit_valid, bit_val, bit_ready;
    logic [COLOR_W-1:0]   first_px;
    assign wr_ok      = wr_en && int'(wr_addr) < NUM_LEDS;
    assign latch_end  = state == LATCH && lat_cnt == LW'(RESET_CYCLES - 1);
    assign frame_done = latch_end;
    assign busy       = state != IDLE && !latch_end;
    // START already emits the first bit, so it must see a same-cycle write to pixel 0.
    assign first_px   = (wr_ok && wr_addr == '0) ? wr_data : shadow[0];
`ifdef WS2812_AUTO_REFRESH_EN
    localparam int TW = $clog2(REFRESH_CYCLES);
    logic [TW-1:0] timer;
    always_ff @(posedge clk) begin
        if (rst) timer <= TW'(REFRESH_CYCLES - 1);
        else if (state == START) timer <= TW'(REFRESH_CYCLES - 2);
        else if (timer != '0) timer <= timer - 1'b1;
    end
    assign req = frame_req || timer == '0;
`else
    assign req = frame_req;
`endif
    always_comb begin
        state_n   = state;
        bit_valid = 1'b0;
        bit_val   = 1'b0;
        case (state)
            IDLE:  state_n = req ? START : IDLE;
            START: begin
                state_n   = SEND;
                bit_valid = 1'b1;
                bit_val   = first_px[COLOR_W-1];
            end
            SEND: if (bit_ready) begin
                state_n   = last ? LATCH : SEND;
                bit_valid = !last;
                bit_val   = !last && active[pix][bit_idx];
            end
            LATCH: state_n = latch_end ? ((pending || req) ? START : IDLE) : LATCH;
            default: state_n = IDLE;
        endcase
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            pending <= 1'b0;
            pix     <= '0;
            bit_idx <= '0;
            last    <= 1'b0;
            lat_cnt <= '0;
            for (int i = 0; i < NUM_LEDS; i++) begin
                shadow[i] <= '0;
                active[i] <= '0;
            end
        end else begin
            state   <= state_n;
            pending <= state_n == START ? 1'b0 : pending | req;
            lat_cnt <= state == LATCH && !latch_end ? lat_cnt + 1'b1 : '0;
            if (wr_ok) shadow[wr_addr] <= wr_data;
            if (state == START) begin
                for (int i = 0; i < NUM_LEDS; i++)
                    active[i] <= (wr_ok && int'(wr_addr) == i) ? wr_data : shadow[i];
                pix     <= '0;
                bit_idx <= 5'd22;
                last    <= 1'b0;
            end else if (state == SEND && bit_valid) begin
                last    <= int'(pix) == NUM_LEDS - 1 && bit_idx == 5'd0;
                bit_idx <= bit_idx == 5'd0 ? 5'd23 : bit_idx - 1'b1;
                pix     <= (bit_idx == 5'd0 && int'(pix) != NUM_LEDS - 1) ? pix + 1'b1 : pix;
            end
        end
    end
    ws2812_bit_encoder #(
        .BIT_CYCLES(BIT_CYCLES),
        .T1H_CYCLES(T1H_CYCLES),
        .T0H_CYCLES(T0H_CYCLES)
    ) u_enc (
        .clk      (clk),
        .rst      (rst),
        .bit_valid(bit_valid),
        .bit_val  (bit_val),
        .bit_ready(bit_ready),
        .data_out (led_data_out)
    );
endmodule

// File: tb/tb_ws2812_chain_scheduler.sv
// tb_ws2812_chain_scheduler: random-data frame checks against a pixel-level waveform model.
module tb_ws2812_chain_scheduler;
    localparam int N    = 3;
    localparam int BITC = 63;
    localparam int T1H  = 40;
    localparam int T0H  = 20;
    localparam int RSTC = 10000;
    logic        clk = 1'b0;
    logic        rst, wr_en, frame_req;
    logic [1:0]  wr_addr;
    logic [23:0] wr_data;
    logic        busy, frame_done, led_data_out;
    logic [23:0] sh [N];
    int          n_chk = 0;
    int          n_fail = 0;
    always #10 clk = ~clk;
    ws2812_chain_scheduler #(.NUM_LEDS(N)) dut (
        .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .frame_req(frame_req), .busy(busy), .frame_done(frame_done), .led_data_out(led_data_out)
    );
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask
    task automatic wr(input int a, input logic [23:0] d);
        @(posedge clk);
        #1 wr_en = 1'b1; wr_addr = a[1:0]; wr_data = d;
        if (a < N) sh[a] = d;
        @(posedge clk);
        #1 wr_en = 1'b0;
    endtask
    task automatic pulse();
        @(posedge clk);
        #1 frame_req = 1'b1;
        @(posedge clk);
        #1 frame_req = 1'b0;
    endtask
    // Called just before the negedge of the START cycle; returns at the negedge of frame_done.
    task automatic watch();
        logic [23:0] e [N];
        int bad, lead, tot, hi;
        @(negedge clk);
        e = sh;
        check("start_busy", 32'(busy), 1);
        check("start_led", 32'(led_data_out), 0);
        bad = 0;
        for (int p = 0; p < N; p++)
            for (int k = 0; k < 24; k++) begin
                lead = 0;
                tot  = 0;
                hi   = e[p][23-k] ? T1H : T0H;
                for (int c = 0; c < BITC; c++) begin
                    @(negedge clk);
                    if (led_data_out) tot++;
                    if (led_data_out && lead == c) lead++;
                    if (!busy || frame_done) bad++;
                end
                check($sformatf("bit_p%0d_b%0d", p, 23 - k), 32'(lead * 256 + tot), 32'(hi * 257));
            end
        check("send_flags", 32'(bad), 0);
        bad = 0;
        for (int c = 0; c < RSTC; c++) begin
            @(negedge clk);
            if (led_data_out) bad++;
            if (c < RSTC - 1) begin
                if (!busy || frame_done) bad++;
            end else begin
                check("frame_done", 32'(frame_done), 1);
                check("busy_fall", 32'(busy), 0);
            end
        end
        check("latch_gap", 32'(bad), 0);
    endtask
    task automatic idle_check(input string tag, input int n);
        int bad = 0;
        repeat (n) begin
            @(negedge clk);
            if (busy || frame_done || led_data_out) bad++;
        end
        check(tag, 32'(bad), 0);
    endtask
    initial begin
        int bad;
        logic [23:0] r;
        rst = 1'b1; wr_en = 1'b0; wr_addr = '0; wr_data = '0; frame_req = 1'b0;
        for (int i = 0; i < N; i++) sh[i] = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_led", 32'(led_data_out), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_done", 32'(frame_done), 0);
        @(posedge clk);
        #1 rst = 1'b0;
        // Frame 1: fixed pattern; a SEND-time write must not alter it, out-of-range write ignored.
        wr(0, 24'hFF0000);
        wr(1, 24'h000001);
        wr(2, 24'($urandom));
        pulse();
        fork
            watch();
            begin
                repeat (500) @(posedge clk);
                wr(0, 24'h00FF00);
                wr(3, 24'($urandom));
            end
        join
        idle_check("idle_after_f1", 200);
        // Frame 2: write together with frame_req, plus two merged mid-frame requests.
        r = 24'($urandom);
        @(posedge clk);
        #1 frame_req = 1'b1; wr_en = 1'b1; wr_addr = 2'd2; wr_data = r; sh[2] = r;
        @(posedge clk);
        #1 frame_req = 1'b0; wr_en = 1'b0;
        fork
            watch();
            begin
                repeat (300) @(posedge clk);
                pulse();
                repeat (2000) @(posedge clk);
                pulse();
            end
        join
        // Frame 3 (pending) starts right after frame_done; a START-cycle write is forwarded.
        r = 24'($urandom);
        @(posedge clk);
        #1 wr_en = 1'b1; wr_addr = 2'd1; wr_data = r; sh[1] = r;
        fork
            watch();
            begin
                @(posedge clk);
                #1 wr_en = 1'b0;
            end
        join
        idle_check("no_third_frame", 300);
        // Reset mid-SEND aborts without frame_done and clears both banks.
        for (int i = 0; i < N; i++) wr(i, 24'($urandom));
        pulse();
        bad = 0;
        repeat (1500) begin
            @(negedge clk);
            if (frame_done || !busy) bad++;
        end
        @(posedge clk);
        #1 rst = 1'b1;
        for (int i = 0; i < N; i++) sh[i] = '0;
        @(posedge clk);
        @(negedge clk);
        check("midrst_led", 32'(led_data_out), 0);
        check("midrst_busy", 32'(busy), 0);
        check("midrst_done", 32'(frame_done | bad[0]), 0);
        check("pre_rst_frame", 32'(bad), 0);
        @(posedge clk);
        #1 rst = 1'b0;
        idle_check("idle_after_rst", 100);
        pulse();
        watch();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
